angle_sweep_scheduler: RTL and testbench
========================================

Name: angle_sweep_scheduler

Overview:
- Sequences the angle-scoring datapath over a buffer of coarse (theta, phi) candidates.
- For each candidate, sweeps alpha from alpha_min to alpha_max in alpha_step increments.
- Issues one (theta, phi, alpha) request at a time to the scorer and collects each returned score.
- Keeps the best-scoring triple and pulses done when the whole buffer has been swept.

Parameters:
- NUM_CAND, 10, number of candidates in candidate_angle_buffer (1..16).
- ANGLE_W, 12, width of theta, phi and alpha.
- SCORE_W, 16, width of a score (unsigned).
- TIMEOUT_CYC, 255, WAIT timeout in cycles; used only with SWEEP_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- candidate_angle_buffer  in  2*ANGLE_W*NUM_CAND  candidate i at [2*ANGLE_W*(i+1)-1 -: 2*ANGLE_W]; theta in the upper half, phi in the lower half.
- alpha_min  in  ANGLE_W  first alpha of each sweep.
- alpha_max  in  ANGLE_W  last allowed alpha, inclusive.
- alpha_step  in  ANGLE_W  alpha increment; 0 is treated as 1.
- req_valid  out  1  request to scorer.
- req_ready  in  1  scorer accepts the request.
- theta  out  ANGLE_W  request theta.
- phi  out  ANGLE_W  request phi.
- alpha  out  ANGLE_W  request alpha.
- req_cand_idx  out  4  candidate index of the request.
- score_valid  in  1  score returned.
- score  in  SCORE_W  returned score.
- busy  out  1  high from LOAD through DONE.
- done  out  1  one-cycle pulse at sweep end.
- best_valid  out  1  at least one score was accepted.
- best_theta  out  ANGLE_W  best-scoring triple.
- best_phi  out  ANGLE_W  best-scoring triple.
- best_alpha  out  ANGLE_W  best-scoring triple.
- best_cand_idx  out  4  candidate index of the best triple.
- best_score  out  SCORE_W  best score.
- issue_count  out  10  number of requests accepted this sweep.
- timeout_err  out  1  sticky flag; see Optional Feature.

Behaviour:
- Reset: all outputs 0, state IDLE, all internal counters and latches cleared. Reset wins over every other event, including mid-handshake. Any outstanding score after reset is ignored.
- IDLE:
  - start=1 goes to LOAD.
  - On start, latch alpha_min/max/step and candidate_angle_buffer. Later input changes have no effect during the sweep.
  - Clear best_* and issue_count.
- LOAD:
  - If alpha_min > alpha_max, go to DONE (no requests, best_valid stays 0).
  - Otherwise set cand=0, alpha=alpha_min, and go to ISSUE.
- ISSUE:
  - req_valid=1; theta/phi/alpha/req_cand_idx are driven from registers and stay stable while req_ready=0.
  - When req_valid & req_ready: issue_count+1, go to WAIT.
  - req_valid is 0 in every other state.
- WAIT:
  - Only one request is outstanding at a time.
  - score_valid=1: if !best_valid or score > best_score (strict), update all best_* and set best_valid=1. Ties keep the earlier triple. Then go to NEXT.
  - score_valid outside WAIT is ignored.
- NEXT:
  - next_alpha = alpha + step, computed at ANGLE_W+1 bits.
  - If next_alpha > alpha_max (including carry out of ANGLE_W), advance the candidate:
    - If cand == NUM_CAND-1, go to DONE.
    - Otherwise cand+1, alpha=alpha_min, go to ISSUE.
  - Otherwise alpha=next_alpha, go to ISSUE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- best_* and issue_count hold their values until the next accepted start or reset.
- start while busy is ignored. start arriving in the same cycle done is high is also ignored.
- Latency:
  - Start accepted at cycle 0 → LOAD at cycle 1 → first req_valid at cycle 2.
  - Score at cycle t → next req_valid at cycle t+2.

Optional Feature:
- SWEEP_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYC cycles without score_valid, the point is treated as scored 0 (no best update unless best_valid=0) and the block goes to NEXT.
  - timeout_err is set sticky and cleared only on the next accepted start or on reset.
- Not defined: WAIT blocks indefinitely; timeout_err is tied to 0.

Test Plan:
- Point count and best selection:
  - Stimulus: candidate i = (i+1)*21 (theta=0, phi=(i+1)*21); alpha 0..32, step 16; req_ready=1; scorer returns alpha+4*cand one cycle later.
  - Response: 30 requests, issue_count=30, best = cand 9, phi 210, alpha 32, score 68; single done pulse.
- Tie handling: constant score 100 → best_cand_idx=0, best_alpha=0, best_score=100, best_valid=1.
- Alpha overflow: alpha_min=4080, alpha_max=4095, step=16 → one request per candidate (alpha 4080 only), issue_count=10, no wrap to low alpha.
- Backpressure: req_ready held 0 for 5 cycles in ISSUE → req_valid stays 1, theta/phi/alpha stable, issue_count unchanged until the ready cycle.
- Reset mid-operation: rst=1 in WAIT at cand 4 → next cycle all outputs 0, state IDLE; a late score_valid is ignored; a following start sweeps from cand 0.
- Empty range: alpha_min=50, alpha_max=40 → req_valid never asserts, done at cycle 2 after start, best_valid=0. With SWEEP_TIMEOUT_EN and the scorer silent → each point advances after 255 cycles and timeout_err=1.

Source files
------------

// File: rtl/angle_sweep_scheduler_if.sv
// angle_sweep_scheduler_if: scheduler-to-scorer request/score handshake.
// master = scheduler side, slave = scorer side.
interface angle_sweep_scheduler_if #(
    parameter int ANGLE_W = 12,
    parameter int SCORE_W = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [ANGLE_W-1:0] theta;
    logic [ANGLE_W-1:0] phi;
    logic [ANGLE_W-1:0] alpha;
    logic [3:0]         req_cand_idx;
    logic               score_valid;
    logic [SCORE_W-1:0] score;

    modport master (
        output req_valid, theta, phi, alpha, req_cand_idx,
        input  req_ready, score_valid, score
    );

    modport slave (
        input  req_valid, theta, phi, alpha, req_cand_idx,
        output req_ready, score_valid, score
    );
endinterface

// File: rtl/angle_sweep_scheduler.sv
// angle_sweep_scheduler: sweeps alpha over every buffered (theta, phi) candidate, one scorer
// request at a time, and keeps the best-scoring triple. Optional WAIT timeout: SWEEP_TIMEOUT_EN.
module angle_sweep_scheduler #(
    parameter int NUM_CAND    = 10,
    parameter int ANGLE_W     = 12,
    parameter int SCORE_W     = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [2*ANGLE_W*NUM_CAND-1:0]   candidate_angle_buffer,
    input  logic [ANGLE_W-1:0]              alpha_min,
    input  logic [ANGLE_W-1:0]              alpha_max,
    input  logic [ANGLE_W-1:0]              alpha_step,
    angle_sweep_scheduler_if.master         bus,
    output logic                            busy,
    output logic                            done,
    output logic                            best_valid,
    output logic [ANGLE_W-1:0]              best_theta,
    output logic [ANGLE_W-1:0]              best_phi,
    output logic [ANGLE_W-1:0]              best_alpha,
    output logic [3:0]                      best_cand_idx,
    output logic [SCORE_W-1:0]              best_score,
    output logic [9:0]                      issue_count,
    output logic                            timeout_err
);
    localparam int CW = 2 * ANGLE_W;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_WAIT, ST_NEXT, ST_DONE} state_t;
    state_t state, state_nx;

    logic [CW*NUM_CAND-1:0] buf_r;
    logic [ANGLE_W-1:0]     amin_r, amax_r, step_r;
    logic [ANGLE_W-1:0]     theta_r, phi_r, alpha_r;
    logic [3:0]             cand_r;
    logic [ANGLE_W:0]       alpha_sum;
    logic                   alpha_over, cand_last, take_score, better, timed_out;
    logic [3:0]             sel_idx;
    logic [CW-1:0]          sel_word;
    logic [SCORE_W-1:0]     eff_score;

    // Carry out of ANGLE_W counts as overshooting alpha_max, so the sweep never wraps.
    assign alpha_sum  = {1'b0, alpha_r} + {1'b0, step_r};
    assign alpha_over = alpha_sum > {1'b0, amax_r};
    assign cand_last  = (cand_r == 4'(NUM_CAND - 1));
    assign sel_idx    = (state == ST_LOAD) ? 4'd0 : cand_r + 4'd1;
    assign sel_word   = buf_r[32'(sel_idx) * CW +: CW];

    assign take_score = (state == ST_WAIT) && (bus.score_valid || timed_out);
    assign eff_score  = bus.score_valid ? bus.score : '0;
    assign better     = !best_valid || (eff_score > best_score);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_LOAD;
            ST_LOAD:  state_nx = (amin_r > amax_r) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (bus.req_ready) state_nx = ST_WAIT;
            ST_WAIT:  if (take_score) state_nx = ST_NEXT;
            ST_NEXT:  state_nx = (alpha_over && cand_last) ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_valid = (state == ST_ISSUE);
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
    end

    assign bus.theta        = theta_r;
    assign bus.phi          = phi_r;
    assign bus.alpha        = alpha_r;
    assign bus.req_cand_idx = cand_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_r         <= '0;
            amin_r        <= '0;
            amax_r        <= '0;
            step_r        <= '0;
            theta_r       <= '0;
            phi_r         <= '0;
            alpha_r       <= '0;
            cand_r        <= '0;
            best_valid    <= 1'b0;
            best_theta    <= '0;
            best_phi      <= '0;
            best_alpha    <= '0;
            best_cand_idx <= '0;
            best_score    <= '0;
            issue_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    buf_r         <= candidate_angle_buffer;
                    amin_r        <= alpha_min;
                    amax_r        <= alpha_max;
                    step_r        <= (alpha_step == '0) ? ANGLE_W'(1) : alpha_step;
                    best_valid    <= 1'b0;
                    best_theta    <= '0;
                    best_phi      <= '0;
                    best_alpha    <= '0;
                    best_cand_idx <= '0;
                    best_score    <= '0;
                    issue_count   <= '0;
                end
                ST_LOAD: begin
                    cand_r  <= '0;
                    alpha_r <= amin_r;
                    theta_r <= sel_word[CW-1:ANGLE_W];
                    phi_r   <= sel_word[ANGLE_W-1:0];
                end
                ST_ISSUE: if (bus.req_ready) issue_count <= issue_count + 10'd1;
                ST_WAIT: if (take_score && better) begin
                    best_valid    <= 1'b1;
                    best_theta    <= theta_r;
                    best_phi      <= phi_r;
                    best_alpha    <= alpha_r;
                    best_cand_idx <= cand_r;
                    best_score    <= eff_score;
                end
                ST_NEXT: begin
                    if (!alpha_over) begin
                        alpha_r <= alpha_sum[ANGLE_W-1:0];
                    end else if (!cand_last) begin
                        cand_r  <= cand_r + 4'd1;
                        alpha_r <= amin_r;
                        theta_r <= sel_word[CW-1:ANGLE_W];
                        phi_r   <= sel_word[ANGLE_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] wait_cnt;
    logic          timeout_r;

    // A silent point is scored as 0 on the TIMEOUT_CYC-th WAIT cycle.
    assign timed_out = (state == ST_WAIT) && !bus.score_valid &&
                       (wait_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
            else                  wait_cnt <= '0;
            if (state == ST_IDLE && start) timeout_r <= 1'b0;
            else if (timed_out)            timeout_r <= 1'b1;
        end
    end

    assign timeout_err = timeout_r;
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_angle_sweep_scheduler.sv
// tb_angle_sweep_scheduler: randomized scoreboard bench; requests and end-of-sweep results are
// predicted by a behavioural sweep model and checked by an independent monitor.
`timescale 1ns/1ps
module tb_angle_sweep_scheduler;
    localparam int NUM_CAND    = 10;
    localparam int ANGLE_W     = 12;
    localparam int SCORE_W     = 16;
    localparam int TIMEOUT_CYC = 255;
    localparam int CW          = 2 * ANGLE_W;
    localparam int BW          = CW * NUM_CAND;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [BW-1:0]      cand_buf = '0;
    logic [ANGLE_W-1:0] amin = '0, amax = '0, astep = '0;
    logic               busy, done, best_valid, timeout_err;
    logic [ANGLE_W-1:0] best_theta, best_phi, best_alpha;
    logic [3:0]         best_cand_idx;
    logic [SCORE_W-1:0] best_score;
    logic [9:0]         issue_count;
    logic               sc_valid = 1'b0, late_valid = 1'b0;
    logic [SCORE_W-1:0] sc_score = '0, late_score = '0;

    angle_sweep_scheduler_if #(.ANGLE_W(ANGLE_W), .SCORE_W(SCORE_W)) bus ();
    assign bus.score_valid = sc_valid | late_valid;
    assign bus.score       = late_valid ? late_score : sc_score;

    angle_sweep_scheduler #(
        .NUM_CAND(NUM_CAND), .ANGLE_W(ANGLE_W), .SCORE_W(SCORE_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .candidate_angle_buffer(cand_buf),
        .alpha_min(amin), .alpha_max(amax), .alpha_step(astep),
        .bus(bus),
        .busy(busy), .done(done), .best_valid(best_valid),
        .best_theta(best_theta), .best_phi(best_phi), .best_alpha(best_alpha),
        .best_cand_idx(best_cand_idx), .best_score(best_score),
        .issue_count(issue_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cand; int theta; int phi; int alpha; } req_t;
    typedef struct {
        int bvalid; int bcand; int btheta; int bphi; int balpha; int bscore; int count; int terr;
    } res_t;

    req_t exp_req[$];
    res_t exp_res[$];

    int tests = 0, fails = 0;
    int mode = 0, seed = 0, ready_mode = 0, rand_lat = 0, stop_cand = 16;
    int seen_cnt = 0, expect_rise = -1, done_seen = 0, done_cyc = 0, last_hs_cand = -1;
    int start_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int score_of(input int c, input int a);
        case (mode)
            0:       return a + 4 * c;
            1:       return 100;
            default: return (a * 37 + c * 101 + seed) % 53;
        endcase
    endfunction

    function automatic logic [BW-1:0] rand_buf();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_CAND; i++) b[CW*i +: CW] = CW'($urandom);
        return b;
    endfunction

    // Reference: every candidate, alpha = lo, lo+st, ... while alpha <= hi; best = first strict max.
    task automatic model_sweep(input logic [BW-1:0] b, input int lo, input int hi, input int st_in);
        res_t r;
        req_t q;
        int st, a, s;
        logic [CW-1:0] w;
        r  = '{default: 0};
        st = (st_in == 0) ? 1 : st_in;
        if (lo <= hi) begin
            for (int c = 0; c < NUM_CAND; c++) begin
                w = b[CW*c +: CW];
                a = lo;
                while (a <= hi) begin
                    q.cand  = c;
                    q.theta = int'(w[CW-1:ANGLE_W]);
                    q.phi   = int'(w[ANGLE_W-1:0]);
                    q.alpha = a;
                    exp_req.push_back(q);
                    s = (c >= stop_cand) ? 0 : score_of(c, a);
                    if (c >= stop_cand) r.terr = 1;
                    if (r.bvalid == 0 || s > r.bscore) begin
                        r.bvalid = 1; r.bcand = c; r.btheta = q.theta;
                        r.bphi = q.phi; r.balpha = a; r.bscore = s;
                    end
                    r.count++;
                    a += st;
                end
            end
        end
        exp_res.push_back(r);
    endtask

    initial begin : monitor
        bit prev_valid, prev_done;
        req_t e;
        res_t r;
        prev_valid = 1'b0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (bus.req_valid) begin
                    if (!prev_valid && expect_rise >= 0) begin
                        check("req_latency", cyc, expect_rise);
                        expect_rise = -1;
                    end
                    check("issue_count_live", int'(issue_count), seen_cnt);
                    if (exp_req.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_req: got cand %0d alpha %0d, expected no request",
                                 int'(bus.req_cand_idx), int'(bus.alpha));
                    end else begin
                        e = exp_req[0];
                        check("req_cand",  int'(bus.req_cand_idx), e.cand);
                        check("req_theta", int'(bus.theta), e.theta);
                        check("req_phi",   int'(bus.phi), e.phi);
                        check("req_alpha", int'(bus.alpha), e.alpha);
                        if (bus.req_ready) begin
                            void'(exp_req.pop_front());
                            seen_cnt++;
                            last_hs_cand = e.cand;
`ifdef SWEEP_TIMEOUT_EN
                            if (e.cand >= stop_cand) expect_rise = cyc + TIMEOUT_CYC + 2;
`endif
                        end
                    end
                end
                if (done) begin
                    check("done_single", int'(prev_done), 0);
                    if (exp_res.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
                    end else begin
                        r = exp_res.pop_front();
                        check("best_valid",    int'(best_valid), r.bvalid);
                        check("best_cand_idx", int'(best_cand_idx), r.bcand);
                        check("best_theta",    int'(best_theta), r.btheta);
                        check("best_phi",      int'(best_phi), r.bphi);
                        check("best_alpha",    int'(best_alpha), r.balpha);
                        check("best_score",    int'(best_score), r.bscore);
                        check("issue_count",   int'(issue_count), r.count);
                        check("timeout_err",   int'(timeout_err), r.terr);
                    end
                    done_seen++;
                    done_cyc = cyc;
                end
                prev_valid = bus.req_valid;
                prev_done  = done;
            end
        end
    end

    initial begin : scorer
        int c, a, lat;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_valid && bus.req_ready && int'(bus.req_cand_idx) < stop_cand) begin
                c   = int'(bus.req_cand_idx);
                a   = int'(bus.alpha);
                lat = (rand_lat != 0) ? int'($urandom_range(0, 3)) : 0;
                @(posedge clk); #1;
                repeat (lat) begin @(posedge clk); #1; end
                if (!rst) begin
                    sc_valid    = 1'b1;
                    sc_score    = SCORE_W'(score_of(c, a));
                    expect_rise = cyc + 2;
                    @(posedge clk); #1;
                    sc_valid = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        int vcnt;
        vcnt = 0;
        bus.req_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.req_ready = 1'b1;
                1: bus.req_ready = ($urandom_range(0, 99) < 60);
                default: begin
                    if (!bus.req_valid) begin
                        vcnt = 0;
                        bus.req_ready = 1'b0;
                    end else begin
                        vcnt++;
                        bus.req_ready = (vcnt > 5);
                    end
                end
            endcase
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"},   int'(bus.req_valid), 0);
        check({tag, "_theta"},       int'(bus.theta), 0);
        check({tag, "_phi"},         int'(bus.phi), 0);
        check({tag, "_alpha"},       int'(bus.alpha), 0);
        check({tag, "_cand_idx"},    int'(bus.req_cand_idx), 0);
        check({tag, "_busy"},        int'(busy), 0);
        check({tag, "_done"},        int'(done), 0);
        check({tag, "_best_valid"},  int'(best_valid), 0);
        check({tag, "_best_theta"},  int'(best_theta), 0);
        check({tag, "_best_phi"},    int'(best_phi), 0);
        check({tag, "_best_alpha"},  int'(best_alpha), 0);
        check({tag, "_best_cand"},   int'(best_cand_idx), 0);
        check({tag, "_best_score"},  int'(best_score), 0);
        check({tag, "_issue_count"}, int'(issue_count), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_seen == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_arrived", done_seen - d0, 1);
    endtask

    task automatic do_sweep(input logic [BW-1:0] b, input int lo, input int hi, input int st,
                            input bit scramble);
        int d0;
        cand_buf = b;
        amin     = ANGLE_W'(lo);
        amax     = ANGLE_W'(hi);
        astep    = ANGLE_W'(st);
        model_sweep(b, lo, hi, st);
        d0 = done_seen;
        @(posedge clk); #1;
        start       = 1'b1;
        seen_cnt    = 0;
        start_cyc   = cyc;
        expect_rise = (lo <= hi) ? cyc + 2 : -1;
        @(posedge clk); #1;
        check("busy_after_start", int'(busy), 1);
        if (!scramble) begin
            start = 1'b0;
        end else begin
            cand_buf = rand_buf();
            amin     = ANGLE_W'($urandom);
            amax     = ANGLE_W'($urandom);
            astep    = ANGLE_W'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(d0, 20000);
        check("leftover_reqs", exp_req.size(), 0);
    endtask

    initial begin : main
        logic [BW-1:0] b;
        int d0, n, lo, hi, st;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Point count and best selection.
        b = '0;
        for (int i = 0; i < NUM_CAND; i++) b[CW*i +: CW] = {ANGLE_W'(0), ANGLE_W'((i + 1) * 21)};
        mode = 0; ready_mode = 0; rand_lat = 0;
        do_sweep(b, 0, 32, 16, 1'b0);
        check("plan_issue_count", int'(issue_count), 30);
        check("plan_best_cand",   int'(best_cand_idx), 9);
        check("plan_best_phi",    int'(best_phi), 210);
        check("plan_best_alpha",  int'(best_alpha), 32);
        check("plan_best_score",  int'(best_score), 68);

        // Ties keep the earliest triple.
        mode = 1; ready_mode = 1; rand_lat = 1;
        do_sweep(rand_buf(), 0, 40, 16, 1'b0);
        check("tie_best_cand",  int'(best_cand_idx), 0);
        check("tie_best_alpha", int'(best_alpha), 0);
        check("tie_best_score", int'(best_score), 100);
        check("tie_best_valid", int'(best_valid), 1);

        // Alpha overflow past 4095 must not wrap.
        mode = 2; seed = 7; ready_mode = 0; rand_lat = 0;
        do_sweep(rand_buf(), 4080, 4095, 16, 1'b0);
        check("ovf_issue_count", int'(issue_count), 10);

        // Backpressure: ready low for 5 ISSUE cycles per request.
        mode = 2; seed = 11; ready_mode = 2; rand_lat = 1;
        do_sweep(rand_buf(), 0, 4, 2, 1'b0);

        // Step 0 behaves as step 1.
        mode = 2; seed = 3; ready_mode = 1; rand_lat = 1;
        do_sweep(rand_buf(), 10, 14, 0, 1'b0);
        check("step0_issue_count", int'(issue_count), 50);

        // Empty range; a start in the DONE cycle is ignored.
        ready_mode = 0;
        cand_buf = rand_buf();
        amin = ANGLE_W'(50); amax = ANGLE_W'(40); astep = ANGLE_W'(3);
        model_sweep(cand_buf, 50, 40, 3);
        d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b1; seen_cnt = 0; expect_rise = -1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_done_start", int'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("empty_done_count",   done_seen - d0, 1);
        check("empty_done_latency", done_cyc - start_cyc, 2);
        check("empty_best_valid",   int'(best_valid), 0);
        check("empty_leftover",     exp_res.size(), 0);

        // Randomized sweeps with inputs scrambled after start.
        for (int k = 0; k < 6; k++) begin
            mode = 2; seed = int'($urandom_range(0, 1000));
            ready_mode = (k % 2 == 0) ? 1 : 0; rand_lat = 1;
            lo = int'($urandom_range(0, 4095));
            hi = lo + int'($urandom_range(0, 30));
            if (hi > 4095) hi = 4095;
            st = int'($urandom_range(0, 8));
            do_sweep(rand_buf(), lo, hi, st, 1'b1);
        end

        // Reset while waiting on candidate 4's score.
        mode = 0; stop_cand = 4; ready_mode = 0; rand_lat = 0;
        cand_buf = rand_buf();
        amin = '0; amax = '0; astep = ANGLE_W'(1);
        model_sweep(cand_buf, 0, 0, 1);
        @(posedge clk); #1;
        start = 1'b1; seen_cnt = 0; expect_rise = cyc + 2;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (seen_cnt < 5 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached_cand4", last_hs_cand, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        exp_req.delete();
        exp_res.delete();
        seen_cnt = 0; expect_rise = -1; stop_cand = 16;
        late_valid = 1'b1; late_score = '1;
        @(posedge clk); #1;
        late_valid = 1'b0;
        check("late_score_best_valid", int'(best_valid), 0);
        check("late_score_best_score", int'(best_score), 0);
        check("late_score_busy",       int'(busy), 0);
        mode = 2; seed = 99; ready_mode = 1; rand_lat = 1;
        do_sweep(rand_buf(), 100, 110, 5, 1'b0);

`ifdef SWEEP_TIMEOUT_EN
        // Silent scorer: every point times out and scores 0.
        mode = 0; stop_cand = 0; ready_mode = 0; rand_lat = 0;
        do_sweep(rand_buf(), 0, 0, 1, 1'b0);
        check("timeout_err_sticky", int'(timeout_err), 1);
        check("timeout_best_cand",  int'(best_cand_idx), 0);
        check("timeout_best_score", int'(best_score), 0);
        stop_cand = 16;
`endif

        // Follow-up sweep; also confirms timeout_err clears on a new start.
        mode = 2; seed = 5; ready_mode = 1; rand_lat = 1;
        do_sweep(rand_buf(), 0, 6, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
